// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle MUL/DIVU/REMU sequencer.
// The EX stage imports the same ALU opcode constants for its alu_op mux.
package muldiv_pkg;

  localparam int XLEN     = 32;
  localparam int MD_ITERS = 32;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10,
    MD_RSVD = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational single-iteration datapath: shift-add for MUL, restoring step for DIVU/REMU.
// Drives the external ALU only while run is high; otherwise the ALU inputs are zero.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        run,
  input  logic [1:0]  op,
  input  logic [31:0] acc,
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] mplier,
  input  logic [31:0] mcand,
  input  logic [31:0] divisor,
  input  logic [31:0] alu_out,
  output logic [31:0] acc_nx,
  output logic [31:0] rem_nx,
  output logic [31:0] quot_nx,
  output logic [31:0] mplier_nx,
  output logic [31:0] mcand_nx,
  output logic        alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2
);

  logic [31:0] rem_sh;
  logic        take;

  assign rem_sh = {rem[30:0], quot[31]};
  // rem[31] set means the true shifted value is at least 2^32, so the wrapped difference is exact.
  assign take   = rem[31] | (rem_sh >= divisor);

  always_comb begin
    acc_nx    = acc;
    rem_nx    = rem;
    quot_nx   = quot;
    mplier_nx = mplier;
    mcand_nx  = mcand;
    alu_op    = ALU_ADD;
    alu_in1   = '0;
    alu_in2   = '0;
    if (run) begin
      if (op == MD_MUL) begin
        alu_op    = ALU_ADD;
        alu_in1   = acc;
        alu_in2   = mcand;
        acc_nx    = mplier[0] ? alu_out : acc;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
      end else begin
        alu_op    = ALU_SUB;
        alu_in1   = rem_sh;
        alu_in2   = divisor;
        rem_nx    = take ? alu_out : rem_sh;
        quot_nx   = {quot[30:0], take};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MUL/DIVU/REMU sequencer: IDLE -> RUN (32 ALU iterations) -> DONE -> IDLE.
// Handshakes: a transfer happens on a rising edge where valid & ready; valid holds until then.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  start_op,
  input  logic [31:0] start_a,
  input  logic [31:0] start_b,
  output logic        alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE   = MD_IDLE;
  localparam logic [1:0] S_RUN    = MD_RUN;
  localparam logic [1:0] S_DONE   = MD_DONE;
  localparam logic [4:0] CNT_LAST = 5'(MD_ITERS - 1);

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [31:0] b_q;
  logic [31:0] acc, rem, quot, mplier, mcand;
  logic [4:0]  cnt;

  logic [31:0] acc_nx, rem_nx, quot_nx, mplier_nx, mcand_nx;
  logic        run;

  assign run         = (state == S_RUN);
  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

  muldiv_step u_step (
    .run       (run),
    .op        (op_q),
    .acc       (acc),
    .rem       (rem),
    .quot      (quot),
    .mplier    (mplier),
    .mcand     (mcand),
    .divisor   (b_q),
    .alu_out   (alu_out),
    .acc_nx    (acc_nx),
    .rem_nx    (rem_nx),
    .quot_nx   (quot_nx),
    .mplier_nx (mplier_nx),
    .mcand_nx  (mcand_nx),
    .alu_op    (alu_op),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc      <= '0;
      rem      <= '0;
      quot     <= '0;
      mplier   <= '0;
      mcand    <= '0;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            op_q   <= start_op;
            b_q    <= start_b;
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            quot   <= start_a;
            mplier <= start_b;
            mcand  <= start_a;
            // Reserved op and divide-by-zero resolve immediately without touching the ALU.
            if (start_op == MD_RSVD) begin
              res_data <= '0;
              state    <= S_DONE;
            end else if (start_op != MD_MUL && start_b == '0) begin
              res_data <= (start_op == MD_DIVU) ? 32'hFFFF_FFFF : start_a;
              state    <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc    <= acc_nx;
          rem    <= rem_nx;
          quot   <= quot_nx;
          mplier <= mplier_nx;
          mcand  <= mcand_nx;
          cnt    <= cnt + 5'd1;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            case (op_q)
              MD_MUL:  res_data <= acc_nx;
              MD_DIVU: res_data <= quot_nx;
              default: res_data <= rem_nx;
            endcase
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
